emg_adc_sample_collector: RTL and testbench

- Downstream consumer of the EMG stimulus/sequencer stage, clocked by CLK_EMG.
- Watches EN_ADC_EMG, START_EMG and CH_SEL_EMG, and shifts in the serial ADC result (MSB first).
- Tags each result with its channel and a start-of-frame flag, then buffers it in a synchronous FIFO for the readout/packetiser stage.
- Flags aborted conversions and FIFO overflow.

---
 rtl/emg_adc_sample_collector.sv | 177 +++++++++++++++++
 tb/tb_emg_adc_sample_collector.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/emg_adc_sample_collector.sv
// rtl/emg_adc_sample_collector.sv - EMG serial ADC sample collector with tagged-word FIFO
// Optional channel-sequence checker: define EMG_SEQ_CHECK_EN to build it.
module emg_adc_sample_collector #(
  parameter int NUM_CH     = 16,
  parameter int DATA_BITS  = 12,
  parameter int DOUT_DELAY = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK_EMG,
  input  logic                          RESET_N,
  input  logic                          EN_ADC_EMG,
  input  logic                          START_EMG,
  input  logic [3:0]                    CH_SEL_EMG,
  input  logic                          ADC_DOUT,
  input  logic                          RD_EN,
  output logic [DATA_BITS+4:0]          RD_DATA,
  output logic                          RD_VALID,
  output logic                          EMPTY,
  output logic                          FULL,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          OVERFLOW,
  output logic                          ABORT,
  output logic                          SEQ_ERR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_BITS + 5;
  localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SHIFT, ST_STORE} state_t;

  state_t                 state_q, state_d;
  logic                   start_prev_q;
  logic [3:0]             ch_q, ch_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d, shifted;
  logic [4:0]             cnt_q, cnt_d;
  logic                   abort_q, abort_d;
  logic                   start_det, push_req, push, pop;

  logic [WW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            level_q;
  logic [WW-1:0]          rd_data_q;
  logic                   rd_valid_q, ovf_q;

  assign start_det = START_EMG && !start_prev_q && EN_ADC_EMG;
  assign shifted   = (shreg_q << 1) | DATA_BITS'(ADC_DOUT);
  assign push_req  = (state_q == ST_STORE);
  assign pop       = RD_EN && (level_q != '0);
  // A full FIFO still takes the word when a read frees a slot in the same cycle.
  assign push      = push_req && ((level_q != FULL_LVL) || pop);

  // FSM state register
  always_ff @(posedge CLK_EMG) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and conversion datapath; the START cycle counts towards the
  // data delay, so the last WAIT edge already captures the first data bit.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: begin
        if (start_det) begin
          ch_d    = CH_SEL_EMG;
          shreg_d = '0;
          cnt_d   = '0;
          state_d = (DOUT_DELAY > 0) ? ST_WAIT : ST_SHIFT;
        end
      end
      ST_WAIT, ST_SHIFT: begin
        if (!EN_ADC_EMG) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (start_det) begin
          abort_d = 1'b1;
          ch_d    = CH_SEL_EMG;
          shreg_d = '0;
          cnt_d   = '0;
          state_d = (DOUT_DELAY > 0) ? ST_WAIT : ST_SHIFT;
        end else if (state_q == ST_WAIT) begin
          if (cnt_q == 5'(DOUT_DELAY - 1)) begin
            shreg_d = shifted;
            cnt_d   = 5'd1;
            state_d = (DATA_BITS == 1) ? ST_STORE : ST_SHIFT;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          shreg_d = shifted;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'(DATA_BITS - 1)) state_d = ST_STORE;
        end
      end
      ST_STORE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Conversion datapath registers and START edge history
  always_ff @(posedge CLK_EMG) begin
    if (!RESET_N) begin
      start_prev_q <= 1'b0;
      ch_q         <= '0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
    end else begin
      start_prev_q <= START_EMG;
      ch_q         <= ch_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
    end
  end

  // FIFO storage; read and write of the same slot in one cycle returns the old word
  always_ff @(posedge CLK_EMG) begin
    if (push) mem[wr_ptr_q] <= {(ch_q == 4'd0), ch_q, shreg_q};
  end

  // FIFO pointers, occupancy, registered read port and overflow flag
  always_ff @(posedge CLK_EMG) begin
    if (!RESET_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem[rd_ptr_q];
      end
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
      if (push_req && !push) ovf_q <= 1'b1;
    end
  end

`ifdef EMG_SEQ_CHECK_EN
  logic [3:0] exp_ch_q;
  logic       seq_err_q;

  // Channel-order checker; resyncs to the observed channel after every store
  always_ff @(posedge CLK_EMG) begin
    if (!RESET_N) begin
      exp_ch_q  <= '0;
      seq_err_q <= 1'b0;
    end else if (push_req) begin
      if (ch_q != exp_ch_q) seq_err_q <= 1'b1;
      exp_ch_q <= (ch_q == 4'(NUM_CH - 1)) ? 4'd0 : ch_q + 4'd1;
    end
  end

  assign SEQ_ERR = seq_err_q;
`else
  assign SEQ_ERR = 1'b0;
`endif

  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;
  assign EMPTY    = (level_q == '0);
  assign FULL     = (level_q == FULL_LVL);
  assign LEVEL    = level_q;
  assign OVERFLOW = ovf_q;
  assign ABORT    = abort_q;

endmodule

// File: tb/tb_emg_adc_sample_collector.sv
// tb/tb_emg_adc_sample_collector.sv - scoreboard bench for emg_adc_sample_collector
module tb_emg_adc_sample_collector;

  logic        clk = 1'b0;
  logic        rst_n, en, start, dout, rd_en;
  logic [3:0]  ch_sel;
  logic [16:0] rd_data;
  logic        rd_valid, empty, full, ovf, abort_f, seq_err;
  logic [4:0]  level;

  logic [16:0] sb [$];
  int          mlevel;
  logic [16:0] last_rd;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  emg_adc_sample_collector dut (
    .CLK_EMG(clk), .RESET_N(rst_n), .EN_ADC_EMG(en), .START_EMG(start),
    .CH_SEL_EMG(ch_sel), .ADC_DOUT(dout), .RD_EN(rd_en),
    .RD_DATA(rd_data), .RD_VALID(rd_valid), .EMPTY(empty), .FULL(full),
    .LEVEL(level), .OVERFLOW(ovf), .ABORT(abort_f), .SEQ_ERR(seq_err)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b0; start = 1'b0; dout = 1'b0; rd_en = 1'b0; ch_sel = 4'd0;
    tick(); tick();
    rst_n = 1'b1;
    sb.delete();
    mlevel  = 0;
    last_rd = '0;
  endtask

  task automatic conv(input logic [3:0] ch, input logic [11:0] d, input bit rd_at_store);
    logic [16:0] w, e;
    bit pa, ua;
    w = {(ch == 4'd0), ch, d};
    e = '0;
    en = 1'b1; start = 1'b1; ch_sel = ch;
    tick();
    start = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      dout = d[i];
      tick();
    end
    rd_en = rd_at_store;
    pa = rd_at_store && (mlevel > 0);
    ua = (mlevel < 16) || pa;
    tick();
    rd_en = 1'b0;
    if (pa) begin e = sb.pop_front(); last_rd = e; mlevel--; end
    if (ua) begin sb.push_back(w); mlevel++; end
    n_checks++;
    if (rd_valid !== pa) begin n_fail++; $display("FAIL conv_rd_valid ch=%0d got=%b exp=%b", ch, rd_valid, pa); end
    if (pa) begin
      n_checks++;
      if (rd_data !== e) begin n_fail++; $display("FAIL conv_rd_data got=%h exp=%h", rd_data, e); end
    end
    n_checks++;
    if (level !== 5'(mlevel)) begin n_fail++; $display("FAIL conv_level ch=%0d got=%0d exp=%0d", ch, level, mlevel); end
  endtask

  task automatic read_one(input string tag);
    logic [16:0] e;
    bit pa;
    pa = (mlevel > 0);
    e  = last_rd;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (pa) begin e = sb.pop_front(); last_rd = e; mlevel--; end
    n_checks++;
    if (rd_valid !== pa) begin n_fail++; $display("FAIL %s_rd_valid got=%b exp=%b", tag, rd_valid, pa); end
    n_checks++;
    if (rd_data !== e) begin n_fail++; $display("FAIL %s_rd_data got=%h exp=%h", tag, rd_data, e); end
    n_checks++;
    if (level !== 5'(mlevel)) begin n_fail++; $display("FAIL %s_level got=%0d exp=%0d", tag, level, mlevel); end
  endtask

  task automatic test_reset();
    apply_reset();
    en = 1'b1; start = 1'b1; ch_sel = 4'd2;
    tick();
    start = 1'b0; dout = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; en = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    n_checks++; if (rd_data !== 17'h0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", ovf); end
    n_checks++; if (abort_f !== 1'b0) begin n_fail++; $display("FAIL reset_abort got=%b exp=0", abort_f); end
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err got=%b exp=0", seq_err); end
  endtask

  task automatic test_nominal();
    apply_reset();
    conv(4'd0, 12'hA5C, 1'b0);
    read_one("nominal");
    n_checks++; if (rd_data !== 17'h10A5C) begin n_fail++; $display("FAIL nominal_word got=%h exp=10a5c", rd_data); end
    tick();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL nominal_pulse got=%b exp=0", rd_valid); end
    read_one("empty_read");
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL nominal_empty got=%b exp=1", empty); end
  endtask

  task automatic test_full_frame();
    apply_reset();
    for (int c = 0; c < 16; c++) conv(4'(c), 12'(c * 12'h111), 1'b0);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL frame_full got=%b exp=1", full); end
    for (int c = 0; c < 16; c++) read_one("frame");
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL frame_empty got=%b exp=1", empty); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL frame_overflow got=%b exp=0", ovf); end
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL frame_seq_err got=%b exp=0", seq_err); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int c = 0; c < 16; c++) conv(4'(c), 12'(c * 12'h111), 1'b0);
    conv(4'd0, 12'h7E1, 1'b0);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got=%b exp=1", full); end
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level got=%0d exp=16", level); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    for (int c = 0; c < 16; c++) read_one("ovf_drain");
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got=%b exp=1", empty); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
  endtask

  task automatic test_abort();
    apply_reset();
    conv(4'd0, 12'h123, 1'b0);
    en = 1'b1; start = 1'b1; ch_sel = 4'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin dout = 1'b1; tick(); end
    en = 1'b0;
    tick();
    en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (abort_f !== 1'b1) begin n_fail++; $display("FAIL abort_flag got=%b exp=1", abort_f); end
    n_checks++; if (level !== 5'(mlevel)) begin n_fail++; $display("FAIL abort_level got=%0d exp=%0d", level, mlevel); end
    conv(4'd1, 12'h9F0, 1'b0);
    read_one("abort");
    read_one("abort");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int c = 0; c < 16; c++) conv(4'(c), 12'(12'hF00 - c), 1'b0);
    conv(4'd0, 12'h3C3, 1'b1);
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL b2b_level got=%0d exp=16", level); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got=%b exp=0", ovf); end
    for (int c = 0; c < 16; c++) read_one("b2b_drain");
  endtask

  task automatic test_seq_check();
    logic exp_err;
`ifdef EMG_SEQ_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    apply_reset();
    conv(4'd0, 12'h001, 1'b0);
    conv(4'd1, 12'h002, 1'b0);
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_in_order got=%b exp=0", seq_err); end
    conv(4'd3, 12'h003, 1'b0);
    n_checks++; if (seq_err !== exp_err) begin n_fail++; $display("FAIL seq_skip got=%b exp=%b", seq_err, exp_err); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_full_frame();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_seq_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
